// File: rtl/mcycle_unit_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: operation kind,
// signedness and controller states.
package mcycle_unit_pkg;

    typedef enum logic {
        MC_MUL = 1'b0,
        MC_DIV = 1'b1
    } mc_kind_e;

    typedef enum logic {
        MC_SIGNED   = 1'b0,
        MC_UNSIGNED = 1'b1
    } mc_sign_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPUTING = 2'd1,
        ST_DONE      = 2'd2
    } state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return mc_sign_e'(op[0]) == MC_SIGNED;
    endfunction

endpackage

// File: rtl/mcycle_unit_if.sv
// Decoder/register-file side connection of the multiply/divide unit.
interface mcycle_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       mcycle_op;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [WIDTH-1:0] result1;
    logic [WIDTH-1:0] result2;
    logic             busy;

    modport master (output start, mcycle_op, operand1, operand2,
                    input  result1, result2, busy);
    modport slave  (input  start, mcycle_op, operand1, operand2,
                    output result1, result2, busy);
endinterface

// File: rtl/mcycle_sign_fix.sv
// Conditional two's-complement negation, used for operand magnitudes and
// for restoring the sign of results.
module mcycle_sign_fix #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] value_in,
    input  logic             negate,
    output logic [WIDTH-1:0] value_out
);
    assign value_out = negate ? (~value_in + WIDTH'(1)) : value_in;
endmodule

// File: rtl/mcycle_unit.sv
// Iterative multiply (shift-add) / divide (restoring) unit, one bit per cycle,
// operating on magnitudes with sign correction applied when the result is registered.
module mcycle_unit
    import mcycle_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mcycle_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    mc_kind_e           kind_q, kind_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               dz_q, dz_d;
    logic               armed_q, armed_d;
    logic [WIDTH-1:0]   orig1_q, orig1_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result1_q, result1_d;
    logic [WIDTH-1:0]   result2_q, result2_d;
    logic               busy_c;

    logic               sgn1, sgn2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] iter_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;

    assign sgn1 = op_is_signed(bus.mcycle_op) & bus.operand1[WIDTH-1];
    assign sgn2 = op_is_signed(bus.mcycle_op) & bus.operand2[WIDTH-1];

    mcycle_sign_fix #(.WIDTH(WIDTH)) u_abs1 (.value_in(bus.operand1), .negate(sgn1), .value_out(mag1));
    mcycle_sign_fix #(.WIDTH(WIDTH)) u_abs2 (.value_in(bus.operand2), .negate(sgn2), .value_out(mag2));

    // MUL: acc = {partial product high, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // DIV: acc = {partial remainder, dividend bits / quotient bits}, shifted left each step.
    // The shifted remainder needs WIDTH+1 bits; after a successful subtract it fits in WIDTH.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_rem   = div_shift[WIDTH-1:0] - b_q;
    assign div_next  = div_ge ? {div_rem,               acc_q[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0};

    assign iter_next = (kind_q == MC_MUL) ? mul_next : div_next;

    mcycle_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.value_in(iter_next), .negate(s1_q ^ s2_q), .value_out(prod_fixed));
    mcycle_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.value_in(iter_next[WIDTH-1:0]), .negate(s1_q ^ s2_q), .value_out(quo_fixed));
    mcycle_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.value_in(iter_next[2*WIDTH-1:WIDTH]), .negate(s1_q), .value_out(rem_fixed));

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        kind_d    = kind_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        dz_d      = dz_q;
        armed_d   = armed_q;
        orig1_d   = orig1_q;
        b_d       = b_q;
        acc_d     = acc_q;
        result1_d = result1_q;
        result2_d = result2_q;
        busy_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A Start still held from the previous instruction must drop before relaunch.
                if (!bus.start) armed_d = 1'b1;
                busy_c = bus.start & armed_q;
                if (bus.start && armed_q) begin
                    kind_d  = mc_kind_e'(bus.mcycle_op[1]);
                    s1_d    = sgn1;
                    s2_d    = sgn2;
                    dz_d    = (mc_kind_e'(bus.mcycle_op[1]) == MC_DIV) && (bus.operand2 == '0);
                    orig1_d = bus.operand1;
                    if (mc_kind_e'(bus.mcycle_op[1]) == MC_DIV) begin
                        acc_d = {{WIDTH{1'b0}}, mag1};
                        b_d   = mag2;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, mag2};
                        b_d   = mag1;
                    end
                    count_d = '0;
                    state_d = ST_COMPUTING;
                end
            end
            ST_COMPUTING: begin
                busy_c  = 1'b1;
                acc_d   = iter_next;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH-1)) begin
                    state_d = ST_DONE;
                    if (kind_q == MC_MUL) begin
                        result1_d = prod_fixed[WIDTH-1:0];
                        result2_d = prod_fixed[2*WIDTH-1:WIDTH];
                    end else if (dz_q) begin
                        result1_d = '1;
                        result2_d = orig1_q;
                    end else begin
                        result1_d = quo_fixed;
                        result2_d = rem_fixed;
                    end
                end
            end
            ST_DONE: begin
                armed_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            kind_q    <= MC_MUL;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            dz_q      <= 1'b0;
            armed_q   <= 1'b1;
            orig1_q   <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            result1_q <= '0;
            result2_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            kind_q    <= kind_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            dz_q      <= dz_d;
            armed_q   <= armed_d;
            orig1_q   <= orig1_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            result1_q <= result1_d;
            result2_q <= result2_d;
        end
    end

    assign bus.busy    = busy_c & ~rst;
    assign bus.result1 = result1_q;
    assign bus.result2 = result2_q;

endmodule
